// File: rtl/led_pwm_fader.sv
`timescale 1ns/1ps
// led_pwm_fader: per-channel PWM LED driver whose brightness ramps linearly
// toward each channel's on/off target, one level step per prescaler tick.
module led_pwm_fader #(
  parameter int unsigned NUM_LEDS  = 4,
  parameter int unsigned PWM_WIDTH = 8,
  parameter int unsigned DIV_WIDTH = 32,
  parameter int unsigned FADE_DIV  = 48_828
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [NUM_LEDS-1:0] pattern_in,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam logic [PWM_WIDTH-1:0] MAX_LEVEL = '1;
  localparam logic [PWM_WIDTH-1:0] PWM_LAST  = MAX_LEVEL - 1'b1;
  localparam logic [DIV_WIDTH-1:0] FADE_LAST = DIV_WIDTH'(FADE_DIV - 1);

  typedef enum logic [1:0] {
    CH_OFF,
    CH_RAMP_UP,
    CH_ON,
    CH_RAMP_DOWN
  } ch_state_e;

  logic [NUM_LEDS-1:0]                pattern_q;
  logic [NUM_LEDS-1:0][PWM_WIDTH-1:0] level;
  logic [NUM_LEDS-1:0][PWM_WIDTH-1:0] level_next;
  logic [PWM_WIDTH-1:0]               pwm_cnt;
  logic [DIV_WIDTH-1:0]               fade_cnt;
  logic [NUM_LEDS-1:0]                led_next;
  logic [NUM_LEDS-1:0]                mismatch;
  logic                               tick;
  ch_state_e                          ch_state [NUM_LEDS];

  assign tick = (fade_cnt == FADE_LAST);
  assign busy = |mismatch;

  // Channel state is derived from level and target, never stored, so a target
  // reversal simply flips the step direction from the current level.
  always_comb begin
    level_next = level;
    led_next   = '0;
    mismatch   = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (pattern_q[i]) ch_state[i] = (level[i] == MAX_LEVEL) ? CH_ON : CH_RAMP_UP;
      else              ch_state[i] = (level[i] == '0) ? CH_OFF : CH_RAMP_DOWN;

      mismatch[i] = (ch_state[i] == CH_RAMP_UP) || (ch_state[i] == CH_RAMP_DOWN);
      led_next[i] = (level[i] == MAX_LEVEL) || (pwm_cnt < level[i]);

      if (tick) begin
        case (ch_state[i])
          CH_RAMP_UP:   level_next[i] = level[i] + 1'b1;
          CH_RAMP_DOWN: level_next[i] = level[i] - 1'b1;
          default:      level_next[i] = level[i];
        endcase
      end
    end
  end

  // NOTE: all state, levels included, clears asynchronously on rst; state is
  // written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q <= '0;
      level     <= '0;
      pwm_cnt   <= '0;
      fade_cnt  <= '0;
      led_out   <= '0;
    end else begin
      pattern_q <= pattern_in;
      if (!enable) begin
        pwm_cnt  <= '0;
        fade_cnt <= '0;
        led_out  <= '0;
      end else begin
        pwm_cnt  <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
        fade_cnt <= tick ? '0 : fade_cnt + 1'b1;
        led_out  <= led_next;
        level    <= level_next;
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
`timescale 1ns/1ps
// tb_led_pwm_fader: random and directed stimulus checked cycle by cycle against
// an arithmetic model of level ramps, prescaler ticks and PWM duty.
module tb_led_pwm_fader;

  localparam int NL   = 4;
  localparam int PW   = 4;
  localparam int FD   = 2;
  localparam int MAXL = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [NL-1:0] pattern_in;
  logic [NL-1:0] led_out;
  logic          busy;

  logic          d_rst;
  logic          d_enable;
  logic [NL-1:0] d_pattern;
  logic [NL-1:0] d_led;
  logic          d_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: level per channel, registered target, enabled-cycle count
  int            m_level [NL];
  bit [NL-1:0]   m_pq;
  bit [NL-1:0]   m_led;
  int            m_n;

  always #5 clk = ~clk;

  led_pwm_fader #(.NUM_LEDS(NL), .PWM_WIDTH(PW), .DIV_WIDTH(32), .FADE_DIV(FD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern_in(pattern_in),
    .led_out(led_out), .busy(busy)
  );

  led_pwm_fader #(.NUM_LEDS(NL), .PWM_WIDTH(PW), .DIV_WIDTH(8), .FADE_DIV(75)) dut_duty (
    .clk(clk), .rst(d_rst), .enable(d_enable), .pattern_in(d_pattern),
    .led_out(d_led), .busy(d_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NL; i++) m_level[i] = 0;
    m_pq  = '0;
    m_led = '0;
    m_n   = 0;
  endfunction

  function automatic bit m_busy();
    for (int i = 0; i < NL; i++)
      if (m_level[i] != (m_pq[i] ? MAXL : 0)) return 1'b1;
    return 1'b0;
  endfunction

  // One rising edge: PWM phase and tick follow from the count of enabled cycles.
  function automatic void model_edge(input bit en, input bit [NL-1:0] pat);
    if (en) begin
      for (int i = 0; i < NL; i++)
        m_led[i] = (m_level[i] == MAXL) || ((m_n % MAXL) < m_level[i]);
      if ((m_n % FD) == FD - 1) begin
        for (int i = 0; i < NL; i++) begin
          int tgt;
          tgt = m_pq[i] ? MAXL : 0;
          if (m_level[i] < tgt)      m_level[i]++;
          else if (m_level[i] > tgt) m_level[i]--;
        end
      end
      m_n++;
    end else begin
      m_led = '0;
      m_n   = 0;
    end
    m_pq = pat;
  endfunction

  task automatic check_all();
    check("led_out", 32'(led_out), 32'(m_led));
    check("busy", 32'(busy), 32'(m_busy()));
    for (int i = 0; i < NL; i++)
      check($sformatf("level%0d", i), 32'(dut.level[i]), m_level[i]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(enable, pattern_in);
    @(negedge clk);
    check_all();
  endtask

  task automatic run_until(input int ch, input int val, input int budget, input string tag);
    int k = 0;
    while (m_level[ch] != val && k < budget) begin
      cycle();
      k++;
    end
    check(tag, 32'(dut.level[ch]), val);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    rst        = 1'b1;
    enable     = 1'b0;
    pattern_in = '0;
    d_rst      = 1'b1;
    d_enable   = 1'b0;
    d_pattern  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();

    // Ramp up channel 0 straight out of reset
    rst = 1'b0; enable = 1'b1; pattern_in = 4'b0001;
    repeat (29) cycle();
    check("ramp_l14", 32'(dut.level[0]), 14);
    check("ramp_busy14", 32'(busy), 1);
    cycle();
    check("ramp_l15", 32'(dut.level[0]), 15);
    check("ramp_busy15", 32'(busy), 0);
    repeat (15) begin
      cycle();
      check("ramp_led_on", 32'(led_out), 32'(4'b0001));
    end

    // Asynchronous reset mid-ramp
    pattern_in = 4'b1111;
    repeat (10) cycle();
    #2 rst = 1'b1;
    #1;
    check("rst_led", 32'(led_out), 0);
    check("rst_busy", 32'(busy), 0);
    for (int i = 0; i < NL; i++) check($sformatf("rst_level%0d", i), 32'(dut.level[i]), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0; enable = 1'b1; pattern_in = 4'b0001;

    // Enable gating at level 9
    run_until(0, 9, 40, "gate_reach9");
    enable = 1'b0;
    cycle();
    check("gate_led", 32'(led_out), 0);
    repeat (50) begin
      cycle();
      check("gate_hold9", 32'(dut.level[0]), 9);
      check("gate_busy", 32'(busy), 1);
    end
    enable = 1'b1;
    run_until(0, 10, 10, "gate_resume10");
    run_until(0, 11, 10, "gate_resume11");

    // Reversal on channel 2 at level 7
    pattern_in = 4'b0100;
    run_until(2, 7, 40, "rev_reach7");
    pattern_in = 4'b0000;
    repeat (40) cycle();
    check("rev_zero", 32'(dut.level[2]), 0);
    check("rev_busy", 32'(busy), 0);

    // Rotation chase
    pattern_in = 4'b0011;
    repeat (40) cycle();
    pattern_in = 4'b0110;
    repeat (40) cycle();
    check("chase_l0", 32'(dut.level[0]), 0);
    check("chase_l2", 32'(dut.level[2]), 15);
    pattern_in = 4'b1100;
    repeat (40) cycle();
    check("chase_l1", 32'(dut.level[1]), 0);
    check("chase_l3", 32'(dut.level[3]), 15);

    // Randomized segments
    for (int s = 0; s < 60; s++) begin
      int len;
      pattern_in = NL'($urandom);
      enable     = ($urandom_range(9) != 0);
      len        = $urandom_range(25, 1);
      repeat (len) cycle();
    end

    // Duty cycle at a held level of 5 on the slow-prescaler instance
    d_rst = 1'b0; d_enable = 1'b1; d_pattern = 4'b0010;
    repeat (376) @(negedge clk);
    check("duty_level5", 32'(dut_duty.level[1]), 5);
    check("duty_busy", 32'(d_busy), 1);
    hi = 0;
    repeat (15) begin
      @(negedge clk);
      hi += int'(d_led[1]);
    end
    check("duty_5of15", hi, 5);
    d_enable = 1'b0;
    @(negedge clk);
    check("duty_gate_led", 32'(d_led), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pwm_fader.md
Name: led_pwm_fader

Overview:
- Downstream stage of the rotating LED pattern generator on the Arty board.
- Takes the generator's NUM_LEDS-bit on/off pattern and drives the physical LEDs through per-channel PWM.
- Each LED's brightness ramps linearly toward full or zero rather than snapping, so a rotating pattern shows as a smooth chase.
- Sits between the pattern generator output and the top-level LED pins.

Parameters:
- NUM_LEDS, 4, number of LED channels; matches the pattern generator output width.
- PWM_WIDTH, 8, brightness level width; MAX_LEVEL = 2^PWM_WIDTH-1.
- DIV_WIDTH, 32, width of the fade prescaler counter.
- FADE_DIV, 48_828, clocks per brightness step (about 0.49 ms at 100 MHz; a full ramp of 255 steps is about 124 ms); legal range 1..2^DIV_WIDTH-1.

Ports:
- clk, input, 1, system clock (100 MHz).
- rst, input, 1, asynchronous active-high reset.
- enable, input, 1, high = normal operation; low = outputs dark, levels frozen.
- pattern_in, input, NUM_LEDS, target on/off per channel; synchronous to clk.
- led_out, output, NUM_LEDS, PWM drive to the LEDs; registered.
- busy, output, 1, high while any channel level differs from its target.

Behaviour:
- Reset (async assert, sync release): pattern_q, all levels, pwm_cnt, fade_cnt and led_out are 0. busy is 0.
- pattern_in is registered once into pattern_q. All decisions use pattern_q.
- PWM counter:
  - pwm_cnt counts 0..MAX_LEVEL-1, wraps to 0; period MAX_LEVEL clocks.
  - led_out[i] next = 1 if level[i]==MAX_LEVEL, else (pwm_cnt < level[i]).
  - level 0 means led_out is constantly 0; MAX_LEVEL means constantly 1.
  - Duty cycle is level/MAX_LEVEL.
- Fade prescaler:
  - fade_cnt counts 0..FADE_DIV-1.
  - tick is asserted on the cycle fade_cnt==FADE_DIV-1; fade_cnt then wraps to 0.
  - With FADE_DIV=1, tick is asserted every cycle.
- Per-channel state is derived from level[i] and pattern_q[i]:
  - OFF: level 0, target 0.
  - RAMP_UP: target 1, level < MAX_LEVEL.
  - ON: level MAX_LEVEL, target 1.
  - RAMP_DOWN: target 0, level > 0.
- On tick:
  - RAMP_UP: level+1.
  - RAMP_DOWN: level-1.
  - OFF and ON: hold.
  - Arithmetic saturates; no wrap at 0 or MAX_LEVEL.
- Target reversal mid-ramp: the channel reverses direction from its current level on the next tick; there is no jump.
- Channels are independent. Several channels may step on the same tick.
- Latency:
  - pattern_in change -> pattern_q change: 1 clk.
  - First level change occurs on the next tick after that.
  - level change -> led_out reflects it: 1 clk.
- busy = OR over i of (level[i] != (pattern_q[i] ? MAX_LEVEL : 0)). It is combinational from registers.
- enable low:
  - led_out is forced to 0 on the next clk.
  - pwm_cnt and fade_cnt are cleared to 0 and held.
  - levels are frozen.
  - pattern_q keeps tracking pattern_in.
  - busy still reflects the level/target mismatch.
- enable high again: counting resumes from 0; levels resume from their frozen values.
- Reset mid-ramp: all levels return to 0 immediately (async) and led_out goes to 0.

Test Plan (PWM_WIDTH=4 so MAX_LEVEL=15, FADE_DIV=2, NUM_LEDS=4):
- Reset: assert rst while running -> led_out=0000 and busy=0 immediately; all levels 0 after release.
- Ramp up:
  - Stimulus: pattern_in=0001 held.
  - level[0] steps 1,2,...,15, one step every 2 clks; it reaches 15 after 30 ticks-worth of clks (15 ticks) from pattern_q update.
  - Response: busy deasserts when level[0]=15; led_out[0] is then constantly 1; led_out[3:1]=000.
- PWM duty: hold level[1] at 5 (ramp, then freeze with enable toggling disabled timing) -> led_out[1] is high for exactly 5 of every 15 clks.
- Reversal:
  - Stimulus: ramp channel 2 to level 7, then pattern_in[2]=0.
  - Response: next ticks give levels 6,5,...,0; no overshoot below 0; busy falls at level 0.
- Rotation chase: apply 0011 -> 0110 -> 1100 every 40 clks -> channel 0 ramps down while channel 2 ramps up on the same ticks; both levels are monotonic and saturate.
- Enable gating:
  - Stimulus: drop enable at level[0]=9.
  - Response: led_out=0000 next clk; level[0] stays 9 over 50 clks; busy=1.
  - Restore enable: ramping continues 10,11,...
